// File: rtl/bilinear_line_fetch.sv
// Line-ring controller for the bilinear core: writes source rows into 3 banks (row mod 3) and serves vertical pixel pairs.
// Build option: define LINEBUF_OUTPUT_REG_EN when the line RAMs use their output register (read latency 2 instead of 1).
module bilinear_line_fetch #(
  parameter int DATA_WIDTH = 8,
  parameter int ADDR_WIDTH = 9,
  parameter int IMG_WIDTH  = 320,
  parameter int IMG_HEIGHT = 240,
  parameter int Y_WIDTH    = 12
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  s_valid,
  output logic                  s_ready,
  input  logic [DATA_WIDTH-1:0] s_data,
  input  logic                  s_sof,
  output logic [2:0]            ram_we,
  output logic [ADDR_WIDTH-1:0] ram_waddr,
  output logic [DATA_WIDTH-1:0] ram_wdata,
  output logic [2:0]            ram_re,
  output logic [ADDR_WIDTH-1:0] ram_raddr,
  input  logic [DATA_WIDTH-1:0] ram_rdata0,
  input  logic [DATA_WIDTH-1:0] ram_rdata1,
  input  logic [DATA_WIDTH-1:0] ram_rdata2,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [ADDR_WIDTH-1:0] req_x,
  input  logic [Y_WIDTH-1:0]    req_y,
  input  logic                  req_last,
  output logic                  rsp_valid,
  output logic [DATA_WIDTH-1:0] rsp_top,
  output logic [DATA_WIDTH-1:0] rsp_bot,
  output logic [1:0]            state
);

  // Handshakes: s_* and req_* transfer on a rising edge where valid && ready are both high;
  // ready never looks at valid. The rsp side has no ready: rsp_valid is a one-cycle strobe.

  localparam logic [ADDR_WIDTH-1:0] X_LAST   = ADDR_WIDTH'(IMG_WIDTH - 1);
  localparam logic [ADDR_WIDTH-1:0] X_ONE    = ADDR_WIDTH'(1);
  localparam logic [Y_WIDTH-1:0]    Y_LAST   = Y_WIDTH'(IMG_HEIGHT - 1);
  localparam logic [Y_WIDTH-1:0]    Y_ONE    = Y_WIDTH'(1);
  localparam logic [Y_WIDTH:0]      ROW_LAST = (Y_WIDTH + 1)'(IMG_HEIGHT - 1);
  localparam logic [Y_WIDTH:0]      EXT_ONE  = (Y_WIDTH + 1)'(1);
  localparam logic [Y_WIDTH:0]      EXT_TWO  = (Y_WIDTH + 1)'(2);

  typedef enum logic [1:0] {
    WAIT_SOF = 2'd0,
    WRITE    = 2'd1,
    FULL     = 2'd2
  } wr_state_t;

  wr_state_t             wr_state;
  logic [ADDR_WIDTH-1:0] wr_x;
  logic [Y_WIDTH-1:0]    wr_y;
  logic [Y_WIDTH-1:0]    lines_done;
  logic [Y_WIDTH-1:0]    y_lo;

  function automatic logic [1:0] mod3(input logic [Y_WIDTH-1:0] v);
    logic [Y_WIDTH-1:0] r;
    r = v % Y_WIDTH'(3);
    return r[1:0];
  endfunction

  function automatic logic [2:0] bank_bit(input logic [1:0] b);
    return 3'b001 << b;
  endfunction

  // Bottom row of the pair, clamped to the last image row.
  logic [Y_WIDTH:0]   y_next;
  logic [Y_WIDTH-1:0] y_b;
  assign y_next = {1'b0, req_y} + EXT_ONE;
  assign y_b    = (y_next > ROW_LAST) ? Y_LAST : y_next[Y_WIDTH-1:0];

  logic [Y_WIDTH:0] write_limit;
  assign write_limit = {1'b0, y_lo} + EXT_TWO;

  always_comb begin
    s_ready = 1'b0;
    if (!rst) begin
      case (wr_state)
        WAIT_SOF: s_ready = 1'b1;
        WRITE:    s_ready = ({1'b0, wr_y} <= write_limit);
        default:  s_ready = 1'b0;
      endcase
    end
  end

  assign req_ready = !rst && (wr_state != WAIT_SOF) && (y_b < lines_done);

  logic s_fire, wr_en, req_fire, row_end, frame_end;
  assign s_fire    = s_valid && s_ready;
  assign wr_en     = s_fire && ((wr_state == WRITE) || s_sof);
  assign req_fire  = req_valid && req_ready;
  assign row_end   = (wr_x == X_LAST);
  assign frame_end = wr_en && row_end && (wr_y == Y_LAST);

  logic [1:0] top_bank, bot_bank;
  assign top_bank = mod3(req_y);
  assign bot_bank = mod3(y_b);

  assign ram_we    = wr_en ? bank_bit(mod3(wr_y)) : 3'b000;
  assign ram_waddr = wr_x;
  assign ram_wdata = s_data;
  assign ram_re    = req_fire ? (bank_bit(top_bank) | bank_bit(bot_bank)) : 3'b000;
  assign ram_raddr = req_x;

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_state   <= WAIT_SOF;
      wr_x       <= '0;
      wr_y       <= '0;
      lines_done <= '0;
      y_lo       <= '0;
    end else begin
      if (req_fire) y_lo <= req_y;
      if (wr_en) begin
        if (row_end) begin
          wr_x       <= '0;
          wr_y       <= wr_y + Y_ONE;
          lines_done <= lines_done + Y_ONE;
        end else begin
          wr_x <= wr_x + X_ONE;
        end
      end
      case (wr_state)
        WAIT_SOF: if (wr_en) wr_state <= frame_end ? FULL : WRITE;
        WRITE:    if (frame_end) wr_state <= FULL;
        FULL: begin
          // The consumer's last request of the frame releases the ring for the next frame.
          if (req_fire && req_last) begin
            wr_state   <= WAIT_SOF;
            wr_x       <= '0;
            wr_y       <= '0;
            lines_done <= '0;
            y_lo       <= '0;
          end
        end
        default: wr_state <= WAIT_SOF;
      endcase
    end
  end

  assign state = wr_state;

  // Bank selects travel with the read so the RAM data can be steered when it arrives.
  logic       vld_q;
  logic [1:0] top_q, bot_q;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q <= 1'b0;
      top_q <= '0;
      bot_q <= '0;
    end else begin
      vld_q <= req_fire;
      top_q <= top_bank;
      bot_q <= bot_bank;
    end
  end

  logic [1:0] top_sel, bot_sel;
`ifdef LINEBUF_OUTPUT_REG_EN
  logic       vld_q2;
  logic [1:0] top_q2, bot_q2;
  always_ff @(posedge clk) begin
    if (rst) begin
      vld_q2 <= 1'b0;
      top_q2 <= '0;
      bot_q2 <= '0;
    end else begin
      vld_q2 <= vld_q;
      top_q2 <= top_q;
      bot_q2 <= bot_q;
    end
  end
  assign rsp_valid = vld_q2;
  assign top_sel   = top_q2;
  assign bot_sel   = bot_q2;
`else
  assign rsp_valid = vld_q;
  assign top_sel   = top_q;
  assign bot_sel   = bot_q;
`endif

  always_comb begin
    rsp_top = '0;
    rsp_bot = '0;
    if (rsp_valid) begin
      case (top_sel)
        2'd0:    rsp_top = ram_rdata0;
        2'd1:    rsp_top = ram_rdata1;
        default: rsp_top = ram_rdata2;
      endcase
      case (bot_sel)
        2'd0:    rsp_bot = ram_rdata0;
        2'd1:    rsp_bot = ram_rdata1;
        default: rsp_bot = ram_rdata2;
      endcase
    end
  end

endmodule

// File: tb/tb_bilinear_line_fetch.sv
// Bench for bilinear_line_fetch: 4-wide, 8-high frames, line RAMs modelled here, random pixels and columns.
`timescale 1ns/1ps
module tb_bilinear_line_fetch;
  localparam int DW = 8;
  localparam int AW = 9;
  localparam int YW = 12;
  localparam int W  = 4;
  localparam int H  = 8;
`ifdef LINEBUF_OUTPUT_REG_EN
  localparam int LAT = 2;
`else
  localparam int LAT = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          s_valid, s_ready, s_sof;
  logic [DW-1:0] s_data;
  logic [2:0]    ram_we, ram_re;
  logic [AW-1:0] ram_waddr, ram_raddr;
  logic [DW-1:0] ram_wdata, ram_rdata0, ram_rdata1, ram_rdata2;
  logic          req_valid, req_ready, req_last;
  logic [AW-1:0] req_x;
  logic [YW-1:0] req_y;
  logic          rsp_valid;
  logic [DW-1:0] rsp_top, rsp_bot;
  logic [1:0]    state;

  bilinear_line_fetch #(
    .DATA_WIDTH(DW), .ADDR_WIDTH(AW), .IMG_WIDTH(W), .IMG_HEIGHT(H), .Y_WIDTH(YW)
  ) dut (
    .clk(clk), .rst(rst),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_sof(s_sof),
    .ram_we(ram_we), .ram_waddr(ram_waddr), .ram_wdata(ram_wdata),
    .ram_re(ram_re), .ram_raddr(ram_raddr),
    .ram_rdata0(ram_rdata0), .ram_rdata1(ram_rdata1), .ram_rdata2(ram_rdata2),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y), .req_last(req_last),
    .rsp_valid(rsp_valid), .rsp_top(rsp_top), .rsp_bot(rsp_bot),
    .state(state)
  );

  // Clock.
  always #5 clk = ~clk;

  // Three line RAMs with registered read (plus output register when enabled).
  logic [DW-1:0] mem [3][512];
  logic [DW-1:0] rd1 [3];
  logic [DW-1:0] rd2 [3];
  always @(posedge clk) begin
    for (int b = 0; b < 3; b++) begin
      if (ram_we[b]) mem[b][ram_waddr] <= ram_wdata;
      if (ram_re[b]) rd1[b] <= mem[b][ram_raddr];
      rd2[b] <= rd1[b];
    end
  end
  assign ram_rdata0 = (LAT == 2) ? rd2[0] : rd1[0];
  assign ram_rdata1 = (LAT == 2) ? rd2[1] : rd1[1];
  assign ram_rdata2 = (LAT == 2) ? rd2[2] : rd1[2];

  typedef struct { logic sof; logic [DW-1:0] data; int x; int y; } pix_t;
  typedef struct { int x; int y; logic last; } req_t;

  logic [DW-1:0]   pix [H][W];
  pix_t            src_q[$];
  req_t            req_q[$];
  logic [2*DW-1:0] exp_q[$];
  int              due_q[$];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int m_phase = 0;  // 0 waiting for sof, 1 filling, 2 frame complete
  int m_rows = 0;
  int m_ylo = 0;
  int last_wr_cyc = 0;
  int last_req_cyc = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_s_ready"}, 32'(s_ready), 0);
    check({tag, "_req_ready"}, 32'(req_ready), 0);
    check({tag, "_ram_we"}, 32'(ram_we), 0);
    check({tag, "_ram_re"}, 32'(ram_re), 0);
    check({tag, "_rsp_valid"}, 32'(rsp_valid), 0);
    check({tag, "_rsp_top"}, 32'(rsp_top), 0);
    check({tag, "_rsp_bot"}, 32'(rsp_bot), 0);
    check({tag, "_state"}, 32'(state), 0);
  endtask

  function automatic int bottom_row(input int y);
    return (y + 1 > H - 1) ? H - 1 : y + 1;
  endfunction

  // Driver + scoreboard for one clock cycle.
  task automatic step();
    pix_t p;
    req_t r;
    int   yb;
    logic wr, e_s, e_r;
    s_valid = (src_q.size() > 0);
    s_data  = s_valid ? src_q[0].data : '0;
    s_sof   = s_valid ? src_q[0].sof : 1'b0;
    req_valid = (req_q.size() > 0);
    req_x     = req_valid ? AW'(req_q[0].x) : '0;
    req_y     = req_valid ? YW'(req_q[0].y) : '0;
    req_last  = req_valid ? req_q[0].last : 1'b0;
    @(negedge clk);
    e_s = (m_phase == 0) || ((m_phase == 1) && (m_rows <= m_ylo + 2));
    e_r = req_valid && (m_phase != 0) && (bottom_row(req_q[0].y) < m_rows);
    if (due_q.size() > 0 && due_q[0] == cyc) begin
      check("rsp_valid", 32'(rsp_valid), 1);
      check("rsp_pair", 32'({rsp_top, rsp_bot}), 32'(exp_q[0]));
      void'(exp_q.pop_front());
      void'(due_q.pop_front());
    end else begin
      check("rsp_idle", 32'(rsp_valid), 0);
    end
    if (s_valid) check("s_ready", 32'(s_ready), 32'(e_s));
    if (s_valid && s_ready) begin
      p  = src_q.pop_front();
      wr = (m_phase == 1) || (m_phase == 0 && p.sof);
      if (wr) begin
        check("ram_we", 32'(ram_we), 32'(1 << (p.y % 3)));
        check("ram_waddr", 32'(ram_waddr), 32'(p.x));
        check("ram_wdata", 32'(ram_wdata), 32'(p.data));
        if (m_phase == 0) m_phase = 1;
        if (p.x == W - 1) begin
          m_rows++;
          if (p.y == H - 1) m_phase = 2;
        end
        last_wr_cyc = cyc;
      end else begin
        check("ram_we_drop", 32'(ram_we), 0);
      end
    end else begin
      check("ram_we_off", 32'(ram_we), 0);
    end
    if (req_valid) check("req_ready", 32'(req_ready), 32'(e_r));
    if (req_valid && req_ready) begin
      r  = req_q.pop_front();
      yb = bottom_row(r.y);
      check("ram_re", 32'(ram_re), 32'((1 << (r.y % 3)) | (1 << (yb % 3))));
      check("ram_raddr", 32'(ram_raddr), 32'(r.x));
      exp_q.push_back({pix[r.y][r.x], pix[yb][r.x]});
      due_q.push_back(cyc + LAT);
      m_ylo = r.y;
      last_req_cyc = cyc;
      if (r.last && m_phase == 2) begin
        m_phase = 0;
        m_rows  = 0;
        m_ylo   = 0;
      end
    end else begin
      check("ram_re_off", 32'(ram_re), 0);
    end
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic run_cycles(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic run_until_idle(input int budget, input string tag);
    int n = 0;
    while ((src_q.size() > 0 || req_q.size() > 0) && n < budget) begin
      step();
      n++;
    end
    check({tag, "_timeout"}, 32'(src_q.size() + req_q.size()), 0);
  endtask

  task automatic new_frame();
    for (int y = 0; y < H; y++)
      for (int x = 0; x < W; x++)
        pix[y][x] = DW'($urandom_range(0, 255));
  endtask

  task automatic push_rows(input int y0, input int y1);
    pix_t p;
    for (int y = y0; y <= y1; y++)
      for (int x = 0; x < W; x++) begin
        p.sof = (y == 0 && x == 0);
        p.data = pix[y][x];
        p.x = x;
        p.y = y;
        src_q.push_back(p);
      end
  endtask

  task automatic push_garbage(input int n);
    pix_t p;
    for (int i = 0; i < n; i++) begin
      p.sof = 1'b0;
      p.data = DW'($urandom_range(0, 255));
      p.x = 0;
      p.y = 0;
      src_q.push_back(p);
    end
  endtask

  task automatic push_req(input int x, input int y, input logic last);
    req_t r;
    r.x = x;
    r.y = y;
    r.last = last;
    req_q.push_back(r);
  endtask

  task automatic frame_with_consumer(input string tag);
    int n;
    new_frame();
    push_rows(0, H - 1);
    for (int y = 0; y < H; y++) begin
      n = $urandom_range(1, 3);
      for (int k = 0; k < n; k++)
        push_req($urandom_range(0, W - 1), y, (y == H - 1) && (k == n - 1));
    end
    run_until_idle(800, tag);
    check({tag, "_state_wait"}, 32'(state), 0);
    run_cycles(LAT + 1);
  endtask

  initial begin
    int c0;
    rst = 1'b1;
    s_valid = 1'b0; s_data = '0; s_sof = 1'b0;
    req_valid = 1'b0; req_x = '0; req_y = '0; req_last = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check_reset_outputs("reset");
    rst = 1'b0;

    // Pixels before sof are swallowed without a RAM write.
    push_garbage(3);
    run_until_idle(10, "garbage");
    check("garbage_state", 32'(state), 0);

    // Frame 1, row 0 only: a (2,0) request must wait for row 1.
    new_frame();
    push_rows(0, 0);
    run_until_idle(20, "row0");
    check("row0_state", 32'(state), 1);
    push_req(2, 0, 1'b0);
    step();
    check("req_wait_row1", 32'(req_q.size()), 1);
    push_rows(1, 1);
    run_until_idle(20, "row1");
    check("req_same_cycle_row1", 32'(last_req_cyc), 32'(last_wr_cyc + 1));

    // Consumer holds y=0: row 2 goes in, row 3 must stall.
    push_rows(2, H - 1);
    run_cycles(20);
    check("stall_left", 32'(src_q.size()), 20);
    check("stall_s_ready", 32'(s_ready), 0);
    push_req($urandom_range(0, W - 1), 1, 1'b0);
    step();
    check("req_y1_acc", 32'(req_q.size()), 0);
    run_cycles(12);
    check("row3_left", 32'(src_q.size()), 16);

    for (int y = 2; y <= 5; y++) push_req($urandom_range(0, W - 1), y, 1'b0);
    run_until_idle(200, "fill");
    check("full_state", 32'(state), 2);
    check("full_s_ready", 32'(s_ready), 0);

    // Jump 5 -> 7, last-row single-bank reads, back-to-back until req_last.
    c0 = cyc;
    for (int k = 0; k < 4; k++) push_req($urandom_range(0, W - 1), H - 1, k == 3);
    run_until_idle(20, "last_row");
    check("back_to_back", 32'(last_req_cyc), 32'(c0 + 3));
    check("after_last_state", 32'(state), 0);
    check("after_last_s_ready", 32'(s_ready), 1);
    run_cycles(LAT + 1);

    frame_with_consumer("frame2");

    // Reset in the middle of row 1 of a new frame.
    new_frame();
    push_rows(0, H - 1);
    run_cycles(6);
    check("midrow_written", 32'(src_q.size()), 32'(W * H - 6));
    rst = 1'b1;
    s_valid = 1'b1;
    req_valid = 1'b1; req_x = AW'(1); req_y = '0; req_last = 1'b0;
    @(posedge clk);
    #1;
    cyc++;
    check_reset_outputs("midrow_rst");
    rst = 1'b0;
    src_q.delete();
    req_q.delete();
    m_phase = 0;
    m_rows = 0;
    m_ylo = 0;

    push_garbage(2);
    run_until_idle(10, "post_rst_garbage");
    frame_with_consumer("frame3");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
